// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Purpose  : Writeback stage in front of the register file. ALU results
//            commit one cycle after acceptance. A load waits in WAIT_MEM for
//            the data-memory response, then the byte/halfword/word at the
//            captured offset is extended and committed the following cycle.
//            The register file write port and the retire pulse are registered.
// Ports    : clk, rst                  clock, synchronous active-high reset
//            in_valid / in_ready       upstream handshake
//            in_rd, in_wb_en           destination index, write request
//            in_is_load, in_funct3     load flag and load format
//            in_result                 ALU result, or load address
//            mem_rvalid, mem_rdata     data-memory response (single pulse)
//            writeReg, writeData, rd_we  register file write port
//            retire                    one pulse per completed instruction
//            load_fault                one pulse per abandoned load
// Config   : WB_LOAD_TIMEOUT_EN enables abandoning a load after
//            TIMEOUT_CYCLES cycles in WAIT_MEM; otherwise the stage waits
//            indefinitely and load_fault is constant 0.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic        in_wb_en,
    input  logic        in_is_load,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_result,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  writeReg,
    output logic [31:0] writeData,
    output logic        rd_we,
    output logic        retire,
    output logic        load_fault
);

    // The timeout counter must be able to hold TIMEOUT_CYCLES.
    generate
        if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_cnt_w
            $error("wb_stage: CNT_W too narrow for TIMEOUT_CYCLES");
        end
    endgenerate

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_wait   = 2'd1;
    localparam logic [1:0] c_st_commit = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [4:0]  r_wreg;
    logic [4:0]  w_wreg_nxt;
    logic [31:0] r_wdata;
    logic [31:0] w_wdata_nxt;
    logic        r_we;
    logic        w_we_nxt;
    logic        r_retire;
    logic        w_retire_nxt;
    logic        r_fault;
    logic        w_fault_nxt;
    logic        w_ld_capture;
    logic        w_accept;
    logic        w_timeout;

    // Pending load context
    logic [4:0]  r_ld_rd;
    logic [2:0]  r_ld_funct3;
    logic [1:0]  r_ld_off;

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_data;

    assign in_ready = !rst && ((r_state == c_st_idle) || (r_state == c_st_commit));
    assign w_accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Load data extraction
    // ------------------------------------------------------------------
    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        w_ld_data = mem_rdata;
        case (r_ld_off)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        // offset[0] is deliberately ignored for halfwords: no misalignment trap.
        w_half = r_ld_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_ld_funct3)
            3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ld_data = {24'h000000, w_byte};
            3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_ld_data = {16'h0000, w_half};
            default: w_ld_data = mem_rdata;   // LW and unused encodings
        endcase
    end

    // ------------------------------------------------------------------
    // Optional load timeout
    // ------------------------------------------------------------------
`ifdef WB_LOAD_TIMEOUT_EN
    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + 1'b1;
    // Fires on the WAIT_MEM cycle in which the counter reaches the limit.
    assign w_timeout = (w_cnt_inc == c_timeout);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_ld_capture) begin
            r_cnt <= '0;
        end else if ((r_state == c_st_wait) && !mem_rvalid) begin
            r_cnt <= w_cnt_inc;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_wreg_nxt   = r_wreg;
        w_wdata_nxt  = r_wdata;
        w_we_nxt     = 1'b0;
        w_retire_nxt = 1'b0;
        w_fault_nxt  = 1'b0;
        w_ld_capture = 1'b0;
        case (r_state)
            c_st_idle, c_st_commit: begin
                if (w_accept) begin
                    if (in_is_load) begin
                        w_state_nxt  = c_st_wait;
                        w_ld_capture = 1'b1;
                    end else begin
                        w_state_nxt  = c_st_commit;
                        w_retire_nxt = 1'b1;
                        w_we_nxt     = in_wb_en && (in_rd != 5'd0);
                        // The write port holds its last value on non-writes.
                        if (w_we_nxt) begin
                            w_wreg_nxt  = in_rd;
                            w_wdata_nxt = in_result;
                        end
                    end
                end else begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_wait: begin
                if (mem_rvalid) begin
                    // Response on the expiring cycle takes priority over the timeout.
                    w_state_nxt  = c_st_commit;
                    w_retire_nxt = 1'b1;
                    w_we_nxt     = (r_ld_rd != 5'd0);
                    if (w_we_nxt) begin
                        w_wreg_nxt  = r_ld_rd;
                        w_wdata_nxt = w_ld_data;
                    end
                end else if (w_timeout) begin
                    w_state_nxt  = c_st_commit;
                    w_retire_nxt = 1'b1;
                    w_fault_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_wreg      <= 5'd0;
            r_wdata     <= 32'd0;
            r_we        <= 1'b0;
            r_retire    <= 1'b0;
            r_fault     <= 1'b0;
            r_ld_rd     <= 5'd0;
            r_ld_funct3 <= 3'd0;
            r_ld_off    <= 2'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_wreg   <= w_wreg_nxt;
            r_wdata  <= w_wdata_nxt;
            r_we     <= w_we_nxt;
            r_retire <= w_retire_nxt;
            r_fault  <= w_fault_nxt;
            if (w_ld_capture) begin
                r_ld_rd     <= in_rd;
                r_ld_funct3 <= in_funct3;
                r_ld_off    <= in_result[1:0];
            end
        end
    end

    assign writeReg   = r_wreg;
    assign writeData  = r_wdata;
    assign rd_we      = r_we;
    assign retire     = r_retire;
    assign load_fault = r_fault;

endmodule
`default_nettype wire

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage directly upstream of the register file.
- Accepts retiring instructions from the execute/memory side: ALU result, or a pending load.
- For loads, waits for the data-memory response, then extracts and extends bytes/halfwords.
- Drives the register file write port (writeReg, writeData, rd_we) with a registered, single-cycle write strobe.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles spent in WAIT_MEM before a load is abandoned (used only with WB_LOAD_TIMEOUT_EN).
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  stage can accept this cycle.
- in_rd  input  5  destination register index.
- in_wb_en  input  1  instruction writes rd (0 for stores/branches).
- in_is_load  input  1  instruction is a load.
- in_funct3  input  3  load format.
- in_result  input  32  ALU result; for loads, the address (bits [1:0] = byte offset).
- mem_rvalid  input  1  load data valid, single-cycle pulse.
- mem_rdata  input  32  aligned 32-bit word from data memory.
- writeReg  output  5  register file write index.
- writeData  output  32  register file write data.
- rd_we  output  1  register file write enable.
- retire  output  1  one-cycle pulse per completed instruction.
- load_fault  output  1  one-cycle pulse on load timeout (0 without the feature).

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0, in_ready 0 while rst is high.
- State machine: IDLE, WAIT_MEM, COMMIT.
- in_ready = !rst && (state==IDLE || state==COMMIT). Accept when in_valid && in_ready.
- Non-load accept in cycle N:
  - Goes to COMMIT at N+1.
  - writeReg = in_rd, writeData = in_result.
  - rd_we = in_wb_en && (in_rd != 0).
  - retire = 1 for that cycle.
- Load accept:
  - Captures rd, funct3, offset = in_result[1:0].
  - Goes to WAIT_MEM; counter cleared.
- WAIT_MEM:
  - Stays until mem_rvalid = 1.
  - On mem_rvalid in cycle M: formatted data registered, COMMIT at M+1.
  - rd_we = (rd != 0); loads ignore in_wb_en.
- COMMIT:
  - Lasts exactly one cycle unless a new instruction is accepted the same cycle; the new one follows the same rules.
  - Back-to-back ALU ops therefore commit one per cycle.
  - With no accept, returns to IDLE and rd_we/retire drop to 0.
- Load formatting:
  - 000 LB: byte at offset, sign-extended.
  - 100 LBU: byte at offset, zero-extended.
  - 001 LH: halfword at offset[1], sign-extended.
  - 101 LHU: halfword at offset[1], zero-extended.
  - 010 LW: full word; offset ignored.
  - 011, 110, 111: treated as LW.
  - offset[0] is ignored for halfwords; no misalignment trap.
- rd = 0: the instruction still retires (and loads still wait for mem); rd_we stays 0.
- mem_rvalid outside WAIT_MEM is ignored.
- Reset mid-load: returns to IDLE, pending load dropped, a late mem_rvalid is ignored, no write.
- writeReg/writeData hold their last values when rd_we = 0.

Optional Feature:
- Macro WB_LOAD_TIMEOUT_EN.
- When defined:
  - Counter increments each WAIT_MEM cycle without mem_rvalid.
  - When it reaches TIMEOUT_CYCLES, the next cycle is COMMIT with rd_we = 0, retire = 1, load_fault = 1.
  - mem_rvalid on the expiring cycle wins: normal write, no fault.
- When undefined: WAIT_MEM waits indefinitely; load_fault tied 0; no counter logic.

Test Plan:
- rst 1 for 2 cycles, then idle -> rd_we = 0, writeReg = 0, writeData = 0, retire = 0, in_ready = 1 after release.
- ALU ops back-to-back {rd = 5, 0x1234}, {rd = 6, 0xFFFF0000}, {rd = 0, 0xDEAD} -> rd_we pulses in cycles N+1 and N+2 with matching data; cycle N+3 retire = 1, rd_we = 0; in_ready high throughout.
- Load LB at addr offset 2, rd = 7, mem_rdata = 0x12_80_34_56 after 3 cycles -> in_ready 0 while waiting; writeData = 0xFFFFFF80, rd_we = 1 one cycle after mem_rvalid.
- LHU offset 2 with 0xBEEF1234 -> 0x0000BEEF; LH offset 0 -> 0x00001234; LW -> 0xBEEF1234.
- rst asserted while in WAIT_MEM, then mem_rvalid arrives -> no rd_we, state IDLE, retire 0.
- WB_LOAD_TIMEOUT_EN with TIMEOUT_CYCLES = 4 and no mem_rvalid -> load_fault = 1 and retire = 1 in the same cycle, rd_we = 0, in_ready back high.
